pc_sequencer: RTL and testbench

Fetch-side controller that owns the program counter and sequences instruction fetch for the core. It issues one request at a time to instruction memory and presents each fetched instruction with its PC to the decode stage. It chooses the next PC from sequential (+4), core redirect (branch/jump) or exception vector, and handles stall, halt and redirects that arrive while a fetch is outstanding.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side bundle: imem port, decode port, core control
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        halt;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target,
           exc_valid, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target,
           exc_valid, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and single-outstanding fetch sequencer
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.master     bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        pend, pend_nxt;
  logic        pend_exc, pend_exc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] instr_pc_q, instr_pc_nxt;

  logic [31:0] redir_pc;
  logic        ev_pend, ev_exc;
  logic [31:0] ev_pc;

  assign redir_pc = {bus.redirect_target[31:2], 2'b00};

  // Pending target as it stands after this cycle's events; a stored exception is sticky.
  always_comb begin
    ev_pend = pend;
    ev_exc  = pend_exc;
    ev_pc   = pend_pc;
    if (bus.exc_valid) begin
      ev_pend = 1'b1;
      ev_exc  = 1'b1;
      ev_pc   = EXC_VECTOR;
    end else if (bus.redirect_valid && !pend_exc) begin
      ev_pend = 1'b1;
      ev_exc  = 1'b0;
      ev_pc   = redir_pc;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_nxt     = pend;
    pend_exc_nxt = pend_exc;
    pend_pc_nxt  = pend_pc;
    instr_nxt    = instr_q;
    instr_pc_nxt = instr_pc_q;
    case (state)
      IDLE: state_nxt = bus.halt ? HALTED : FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          if (ev_pend) begin
            pc_nxt       = ev_pc;
            pend_nxt     = 1'b0;
            pend_exc_nxt = 1'b0;
            state_nxt    = bus.halt ? HALTED : FETCH;
          end else begin
            instr_nxt    = bus.imem_rdata;
            instr_pc_nxt = pc;
            state_nxt    = HOLD;
          end
        end else begin
          pend_nxt     = ev_pend;
          pend_exc_nxt = ev_exc;
          pend_pc_nxt  = ev_pc;
        end
      end
      HOLD: begin
        if (bus.exc_valid)           pc_nxt = EXC_VECTOR;
        else if (bus.redirect_valid) pc_nxt = redir_pc;
        else if (bus.instr_ready)    pc_nxt = pc + 32'd4;
        if (bus.exc_valid || bus.redirect_valid || bus.instr_ready)
          state_nxt = bus.halt ? HALTED : FETCH;
      end
      HALTED: begin
        if (bus.exc_valid)           pc_nxt = EXC_VECTOR;
        else if (bus.redirect_valid) pc_nxt = redir_pc;
        if (!bus.halt) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_exc   <= 1'b0;
      pend_pc    <= 32'h0;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend       <= pend_nxt;
      pend_exc   <= pend_exc_nxt;
      pend_pc    <= pend_pc_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.pc          = pc;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          ack;
    logic [31:0] rdata;
    bit          rdy;
    bit          rv;
    logic [31:0] rt;
    bit          ev;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];

  function automatic vec_t mk(bit ack, logic [31:0] rd, bit rdy, bit rv, logic [31:0] rt,
                              bit ev, bit ereq, logic [31:0] eaddr, bit eiv,
                              logic [31:0] einstr, logic [31:0] eipc);
    vec_t v;
    v.ack = ack; v.rdata = rd; v.rdy = rdy; v.rv = rv; v.rt = rt; v.ev = ev;
    v.e_req = ereq; v.e_addr = eaddr; v.e_iv = eiv; v.e_instr = einstr; v.e_ipc = eipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input bit ack, input logic [31:0] rd, input bit rdy, input bit rv,
                        input logic [31:0] rt, input bit ev, input bit h);
    bus.imem_ack = ack; bus.imem_rdata = rd; bus.instr_ready = rdy;
    bus.redirect_valid = rv; bus.redirect_target = rt; bus.exc_valid = ev; bus.halt = h;
    @(negedge clk);
  endtask

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.instr_ready = 0; bus.redirect_valid = 0;
    bus.redirect_target = 0; bus.exc_valid = 0; bus.halt = 0;

    //         ack rdata         rdy rv rt            ev | req addr          iv instr         ipc
    vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h1111_0000, 0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1111_0000, 32'h0));
    vecs.push_back(mk(1, 32'h1111_0001, 0, 0, 32'h0,        0, 1, 32'h4,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h4,        1, 32'h1111_0001, 32'h4));
    vecs.push_back(mk(1, 32'h1111_0002, 0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h8,        1, 32'h1111_0002, 32'h8));
    vecs.push_back(mk(1, 32'h1111_0003, 0, 0, 32'h0,        0, 1, 32'hC,        0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'hC,        1, 32'h1111_0003, 32'hC));
    vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h10,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h10,       0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h1111_0004, 0, 0, 32'h0,        0, 1, 32'h10,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h10,       1, 32'h1111_0004, 32'h10));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h10,       1, 32'h1111_0004, 32'h10));
    vecs.push_back(mk(1, 32'h1111_0005, 1, 0, 32'h0,        0, 1, 32'h14,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 32'h43,       0, 0, 32'h14,       1, 32'h1111_0005, 32'h14));
    vecs.push_back(mk(0, 32'h0,         0, 1, 32'h203,      0, 1, 32'h40,       0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 1, 32'h40,       0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h1111_0006, 0, 0, 32'h0,        0, 1, 32'h200,      0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 32'h300,      1, 0, 32'h200,      1, 32'h1111_0006, 32'h200));
    vecs.push_back(mk(1, 32'h1111_0007, 0, 0, 32'h0,        0, 1, 32'h80,       0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h80,       1, 32'h1111_0007, 32'h80));
    vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h84,       0, 32'h0,         32'h0));

    @(negedge clk); @(negedge clk);
    chk("rst_req",   {31'h0, bus.imem_req},    32'h0);
    chk("rst_iv",    {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_pc",    bus.pc,       32'h0);
    chk("rst_instr", bus.instr,    32'h0);
    chk("rst_ipc",   bus.instr_pc, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("v%0d_req", i),  {31'h0, bus.imem_req},    {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d_iv", i),   {31'h0, bus.instr_valid}, {31'h0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_instr", i), bus.instr,    vecs[i].e_instr);
        chk($sformatf("v%0d_ipc", i),   bus.instr_pc, vecs[i].e_ipc);
      end
      set_in(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rv, vecs[i].rt, vecs[i].ev, 1'b0);
    end

    // pc wrap at the top of the address space
    set_in(1, 32'hB0, 0, 0, 0, 0, 0);
    chk("wrap_ipc84", bus.instr_pc, 32'h84);
    set_in(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    set_in(1, 32'hB1, 0, 0, 0, 0, 0);
    chk("wrap_ipc_top", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", bus.instr, 32'hB1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    chk("wrap_req", {31'h0, bus.imem_req}, 32'h1);
    chk("wrap_addr0", bus.imem_addr, 32'h0);

    // halt in HOLD, consume, stay halted 5 cycles, then fetch pc+4
    set_in(1, 32'hB2, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    chk("halt_hold_iv", {31'h0, bus.instr_valid}, 32'h1);
    set_in(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("halted%0d_req", i), {31'h0, bus.imem_req},    32'h0);
      chk($sformatf("halted%0d_iv", i),  {31'h0, bus.instr_valid}, 32'h0);
      chk($sformatf("halted%0d_pc", i),  bus.pc, 32'h4);
      set_in(0, 0, 0, 0, 0, 0, (i < 4));
    end
    chk("unhalt_req",  {31'h0, bus.imem_req}, 32'h1);
    chk("unhalt_addr", bus.imem_addr, 32'h4);

    // stored exception is not overwritten by a later redirect
    set_in(0, 0, 0, 0, 0, 1, 0);
    chk("pexc_addr", bus.imem_addr, 32'h4);
    set_in(0, 0, 0, 1, 32'h500, 0, 0);
    chk("pexc_addr2", bus.imem_addr, 32'h4);
    set_in(1, 32'hBAD0, 0, 0, 0, 0, 0);
    chk("pexc_vec", bus.imem_addr, 32'h80);
    chk("pexc_iv", {31'h0, bus.instr_valid}, 32'h0);
    set_in(1, 32'hB3, 0, 0, 0, 0, 0);
    chk("pexc_instr", bus.instr, 32'hB3);
    chk("pexc_ipc", bus.instr_pc, 32'h80);

    // redirect and exception while halted update pc only
    set_in(0, 0, 1, 0, 0, 0, 1);
    set_in(0, 0, 0, 1, 32'h601, 0, 1);
    chk("hredir_pc",  bus.pc, 32'h600);
    chk("hredir_req", {31'h0, bus.imem_req}, 32'h0);
    set_in(0, 0, 0, 1, 32'h700, 1, 1);
    chk("hexc_pc", bus.pc, 32'h80);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("hexc_fetch", bus.imem_addr, 32'h80);
    chk("hexc_req", {31'h0, bus.imem_req}, 32'h1);

    // asynchronous reset in the middle of a fetch
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'h0, bus.imem_req},    32'h0);
    chk("arst_iv",    {31'h0, bus.instr_valid}, 32'h0);
    chk("arst_pc",    bus.pc,       32'h0);
    chk("arst_addr",  bus.imem_addr, 32'h0);
    chk("arst_instr", bus.instr,    32'h0);
    chk("arst_ipc",   bus.instr_pc, 32'h0);
    @(negedge clk);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE;
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("late_ack_req",  {31'h0, bus.imem_req},    32'h1);
    chk("late_ack_addr", bus.imem_addr, 32'h0);
    chk("late_ack_iv",   {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    chk("late_ack_wait", {31'h0, bus.imem_req}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
